// File: rtl/m_unit_if.sv
// m_unit_if: execute-stage handshake between the pipeline and the iterative M unit
interface m_unit_if #(parameter int XLEN = 32);
    logic            m_start;
    logic [2:0]      m_func3;
    logic [XLEN-1:0] m_op_a;
    logic [XLEN-1:0] m_op_b;
    logic [4:0]      m_rd;
    logic            flush;
    logic            m_stall;
    logic            m_result_valid;
    logic [XLEN-1:0] m_result;
    logic [4:0]      m_result_rd;
    modport master (
        output m_start, m_func3, m_op_a, m_op_b, m_rd, flush,
        input  m_stall, m_result_valid, m_result, m_result_rd
    );
    modport slave (
        input  m_start, m_func3, m_op_a, m_op_b, m_rd, flush,
        output m_stall, m_result_valid, m_result, m_result_rd
    );
endinterface

// File: rtl/m_unit_iterative.sv
// m_unit_iterative: RV32M multiply/divide, one radix-2 step per cycle on a shared hi/lo datapath
module m_unit_iterative #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic   clk,
    input logic   rst,
    m_unit_if.slave mif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic             sa_q, sb_q;
    logic [XLEN-1:0]  opd, hi, lo;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3;
    logic             sgn_a_op, sgn_b_op, neg_a, neg_b, div0, ovf, special;
    logic [XLEN-1:0]  op_a, op_b, mag_a, mag_b, spec_res;
    assign f3       = mif.m_func3;
    assign op_a     = mif.m_op_a;
    assign op_b     = mif.m_op_b;
    assign sgn_a_op = ~f3[2] ? (f3[1:0] != 2'b11) : ~f3[0];
    assign sgn_b_op = ~f3[2] ? ~f3[1] : ~f3[0];
    assign neg_a    = sgn_a_op & op_a[XLEN-1];
    assign neg_b    = sgn_b_op & op_b[XLEN-1];
    assign mag_a    = neg_a ? -op_a : op_a;
    assign mag_b    = neg_b ? -op_b : op_b;
    assign div0     = f3[2] & (op_b == '0);
    assign ovf      = f3[2] & ~f3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    assign special  = div0 | ovf;
    assign spec_res = div0 ? (f3[1] ? op_a : '1) : (f3[1] ? '0 : op_a);
    // mul: hi:lo shifts right, lo holds the multiplier; div: hi is the partial remainder, lo the dividend/quotient
    logic            is_div, neg_q;
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] hi_n, lo_n, quo, rem, calc_res;
    logic [2*XLEN-1:0] prod, prod_s;
    assign is_div   = f3_q[2];
    assign sum      = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    assign shifted  = {hi, lo[XLEN-1]};
    assign diff     = shifted - {1'b0, opd};
    assign hi_n     = is_div ? (diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    assign lo_n     = is_div ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
    assign neg_q    = sa_q ^ sb_q;
    assign prod     = {hi_n, lo_n};
    assign prod_s   = neg_q ? -prod : prod;
    assign quo      = neg_q ? -lo_n : lo_n;
    assign rem      = sa_q ? -hi_n : hi_n;
    assign calc_res = is_div ? (f3_q[1] ? rem : quo)
                             : (f3_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    assign mif.m_stall        = (state == IDLE && mif.m_start && !mif.flush) || state == CALC;
    assign mif.m_result_valid = state == DONE && !mif.flush;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            f3_q            <= '0;
            rd_q            <= '0;
            sa_q            <= 1'b0;
            sb_q            <= 1'b0;
            opd             <= '0;
            hi              <= '0;
            lo              <= '0;
            cnt             <= '0;
            mif.m_result    <= '0;
            mif.m_result_rd <= '0;
        end else if (mif.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (mif.m_start) begin
                    f3_q <= f3;
                    rd_q <= mif.m_rd;
                    sa_q <= neg_a;
                    sb_q <= neg_b;
                    opd  <= f3[2] ? mag_b : mag_a;
                    lo   <= f3[2] ? mag_a : mag_b;
                    hi   <= '0;
                    cnt  <= '0;
                    if (special) begin
                        mif.m_result    <= spec_res;
                        mif.m_result_rd <= mif.m_rd;
                        state           <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        mif.m_result    <= calc_res;
                        mif.m_result_rd <= rd_q;
                        state           <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
